// File: rtl/uart_cnt_reporter.sv
// Reports a 14-bit counter snapshot over UART TX as "DDDD\r\n" (8N1, LSB first).
// Sequencer, baud divider and serializer share one FSM so every bit is exactly DIV clocks.
`timescale 1ns/1ps
module uart_cnt_reporter #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 9600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] i_digit,
   input  logic        i_send,
   output logic        o_tx,
   output logic        o_busy,
   output logic        o_done
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        state_q;
   logic [CW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [2:0]    char_q;
   logic [13:0]   snap_q;
   logic          tx_q;
   logic          busy_q;
   logic          done_q;
   logic [7:0]    cur_byte;
   logic          bit_end;

   assign bit_end = (baud_q == CW'(DIV - 1));

   // Snapshot is already saturated, so each digit is a plain decimal extraction.
   always_comb begin
      cur_byte = 8'h0A;
      case (char_q)
         3'd0:    cur_byte = 8'h30 + 8'(snap_q / 14'd1000);
         3'd1:    cur_byte = 8'h30 + 8'((snap_q / 14'd100) % 14'd10);
         3'd2:    cur_byte = 8'h30 + 8'((snap_q / 14'd10) % 14'd10);
         3'd3:    cur_byte = 8'h30 + 8'(snap_q % 14'd10);
         3'd4:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         char_q  <= 3'd0;
         snap_q  <= 14'd0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_send) begin
                  snap_q  <= (i_digit >= 14'd10000) ? 14'd9999 : i_digit;
                  char_q  <= 3'd0;
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  baud_q  <= '0;
                  bit_q   <= 3'd0;
                  tx_q    <= cur_byte[0];
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     tx_q  <= cur_byte[bit_q + 3'd1];
                  end
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  baud_q <= '0;
                  if (char_q == 3'd5) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     char_q  <= char_q + 3'd1;
                     tx_q    <= 1'b0;
                     state_q <= S_START;
                  end
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_tx   = tx_q;
   assign o_busy = busy_q;
   assign o_done = done_q;
endmodule

// File: tb/tb_uart_cnt_reporter.sv
// Bench for uart_cnt_reporter: a UART monitor decodes o_tx frames and checks them
// against a queue of expected bytes filled whenever a message is requested.
`timescale 1ns/1ps
module tb_uart_cnt_reporter;
   localparam int CLK_HZ  = 1000;
   localparam int BAUD    = 100;
   localparam int DIV     = 10;
   localparam int MSG_CYC = 60 * DIV;

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic [13:0] i_digit = 14'd0;
   logic        i_send  = 1'b0;
   logic        o_tx;
   logic        o_busy;
   logic        o_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   int         done_cnt = 0;
   int         busy_run = 0;
   int         busy_len = 0;

   logic       mon_act  = 1'b0;
   int         mon_k    = 0;
   int         mon_b    = 0;
   logic [9:0] mon_bits = '0;
   logic       mon_werr = 1'b0;
   logic [7:0] mon_rx;
   logic [7:0] mon_exp;

   uart_cnt_reporter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .clk     (clk),
      .reset   (reset),
      .i_digit (i_digit),
      .i_send  (i_send),
      .o_tx    (o_tx),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every bit must hold one value for all DIV cycles of its slot.
   always @(negedge clk) begin
      if (!reset) begin
         mon_act  = 1'b0;
         busy_run = 0;
      end else begin
         if (o_busy === 1'b1) busy_run++;
         if (o_done === 1'b1) begin
            done_cnt++;
            busy_len = busy_run;
            busy_run = 0;
            $display("done pulse #%0d at cycle %0d, busy lasted %0d cycles", done_cnt, cyc, busy_len);
         end
         if (!mon_act && o_tx === 1'b0) begin
            mon_act  = 1'b1;
            mon_k    = 0;
            mon_werr = 1'b0;
            mon_bits = '0;
         end
         if (mon_act) begin
            mon_b = mon_k / DIV;
            if (mon_k % DIV == 0) mon_bits[mon_b] = o_tx;
            else if (o_tx !== mon_bits[mon_b]) mon_werr = 1'b1;
            if (mon_k == 10 * DIV - 1) begin
               mon_act = 1'b0;
               mon_rx  = mon_bits[8:1];
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL rx_byte: got=%02h required=no byte (unexpected)", mon_rx);
               end else begin
                  mon_exp = exp_q.pop_front();
                  if (mon_rx !== mon_exp || mon_werr || mon_bits[9] !== 1'b1) begin
                     bad++;
                     $display("FAIL rx_byte: got=%02h stop=%b width_err=%b required=%02h stop=1 width_err=0",
                              mon_rx, mon_bits[9], mon_werr, mon_exp);
                  end else begin
                     $display("rx byte %02h at cycle %0d", mon_rx, cyc);
                  end
               end
            end else begin
               mon_k++;
            end
         end
      end
   end

   task automatic push_msg(input int v);
      int s;
      s = (v >= 10000) ? 9999 : v;
      exp_q.push_back(8'h30 + 8'(s / 1000));
      exp_q.push_back(8'h30 + 8'((s / 100) % 10));
      exp_q.push_back(8'h30 + 8'((s / 10) % 10));
      exp_q.push_back(8'h30 + 8'(s % 10));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic pulse_send();
      @(negedge clk);
      i_send = 1'b1;
      @(negedge clk);
      i_send = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (done_cnt < target) begin
         bad++;
         $display("FAIL %s_timeout: done_cnt=%0d required=%0d", tag, done_cnt, target);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if (o_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got=%b required=1", o_tx); end
      total++;
      if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b required=0", o_busy); end
      total++;
      if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got=%b required=0", o_done); end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: tx=%b busy=%b required tx=1 busy=0", o_tx, o_busy);
      end
   endtask

   task automatic test_basic();
      int d0;
      d0 = done_cnt;
      i_digit = 14'd1234;
      push_msg(1234);
      pulse_send();
      total++;
      if (o_busy !== 1'b1 || o_tx !== 1'b0) begin
         bad++;
         $display("FAIL start_latency: busy=%b tx=%b required busy=1 tx=0", o_busy, o_tx);
      end
      wait_done(d0 + 1, MSG_CYC + 50, "basic");
      repeat (20) @(negedge clk);
      total++;
      if (busy_len !== MSG_CYC) begin
         bad++;
         $display("FAIL busy_length: got=%0d required=%0d", busy_len, MSG_CYC);
      end
      total++;
      if (done_cnt !== d0 + 1) begin
         bad++;
         $display("FAIL basic_done_count: got=%0d required=%0d", done_cnt - d0, 1);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL basic_bytes_left: got=%0d required=0", exp_q.size());
      end
   endtask

   task automatic test_values();
      int vals[5] = '{7, 0, 12000, 16383, 9999};
      int d0;
      for (int i = 0; i < 5; i++) begin
         d0 = done_cnt;
         i_digit = 14'(vals[i]);
         push_msg(vals[i]);
         pulse_send();
         wait_done(d0 + 1, MSG_CYC + 50, "values");
         @(negedge clk);
         total++;
         if (exp_q.size() != 0 || busy_len !== MSG_CYC) begin
            bad++;
            $display("FAIL value_%0d: bytes_left=%0d busy=%0d required bytes_left=0 busy=%0d",
                     vals[i], exp_q.size(), busy_len, MSG_CYC);
         end
      end
   endtask

   task automatic test_ignore_busy();
      int d0;
      d0 = done_cnt;
      i_digit = 14'd1234;
      push_msg(1234);
      pulse_send();
      i_digit = 14'd5678;
      repeat (199) @(negedge clk);
      pulse_send();
      wait_done(d0 + 1, MSG_CYC + 50, "ignore");
      repeat (40) @(negedge clk);
      total++;
      if (done_cnt !== d0 + 1) begin
         bad++;
         $display("FAIL ignore_done_count: got=%0d required=1", done_cnt - d0);
      end
      total++;
      if (o_busy !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL ignore_idle: busy=%b bytes_left=%0d required busy=0 bytes_left=0", o_busy, exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int vals[3] = '{42, 8765, 10001};
      int d0;
      int n;
      d0 = done_cnt;
      i_digit = 14'(vals[0]);
      push_msg(vals[0]);
      @(negedge clk);
      i_send = 1'b1;
      for (int m = 0; m < 3; m++) begin
         n = 0;
         @(negedge clk);
         while (o_done !== 1'b1 && n < MSG_CYC + 50) begin
            @(negedge clk);
            n++;
         end
         total++;
         if (o_done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_timeout: message=%0d done=%b required=1", m, o_done);
            i_send = 1'b0;
            break;
         end
         if (m < 2) begin
            i_digit = 14'(vals[m + 1]);
            push_msg(vals[m + 1]);
            @(negedge clk);
            total++;
            if (o_tx !== 1'b0 || o_busy !== 1'b1) begin
               bad++;
               $display("FAIL b2b_gap: tx=%b busy=%b one cycle after done, required tx=0 busy=1", o_tx, o_busy);
            end
         end else begin
            i_send = 1'b0;
         end
      end
      repeat (40) @(negedge clk);
      total++;
      if (done_cnt !== d0 + 3 || exp_q.size() != 0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_end: dones=%0d bytes_left=%0d busy=%b required dones=3 bytes_left=0 busy=0",
                  done_cnt - d0, exp_q.size(), o_busy);
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      i_digit = 14'd1234;
      exp_q.push_back(8'h31);
      exp_q.push_back(8'h32);
      pulse_send();
      repeat (249) @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_outputs: tx=%b busy=%b required tx=1 busy=0", o_tx, o_busy);
      end
      d0 = done_cnt;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      total++;
      if (done_cnt !== d0 || o_busy !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL abort_quiet: dones=%0d busy=%b bytes_left=%0d required dones=0 busy=0 bytes_left=0",
                  done_cnt - d0, o_busy, exp_q.size());
         exp_q.delete();
      end
      i_digit = 14'd5678;
      push_msg(5678);
      pulse_send();
      wait_done(d0 + 1, MSG_CYC + 50, "after_abort");
      @(negedge clk);
      total++;
      if (exp_q.size() != 0 || busy_len !== MSG_CYC) begin
         bad++;
         $display("FAIL after_abort_msg: bytes_left=%0d busy=%0d required bytes_left=0 busy=%0d",
                  exp_q.size(), busy_len, MSG_CYC);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_values();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_cnt_reporter.md
Name: uart_cnt_reporter

Overview:
- Transmit-side companion to the UART command path that drives the run/clear FSM.
- On request, snapshots the 14-bit upcounter value and sends it over UART TX as four ASCII decimal digits followed by CR and LF (8N1, LSB first).
- Contains its own baud-rate divider, character sequencer and serializer.
- Sits beside the upcounter/FND path and drives the board's TX pin.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. Bit period DIV = CLK_HZ/BAUD clocks (integer division; must be ≥ 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_digit  input  14  counter value to report.
- i_send  input  1  request strobe, sampled each clk.
- o_tx  output  1  UART serial line; idle high.
- o_busy  output  1  high while a message is in progress.
- o_done  output  1  one-cycle pulse when a message completes.

Behaviour:
- Reset (reset=0, asynchronous): o_tx=1, o_busy=0, o_done=0; both FSMs go to IDLE; counters and the snapshot clear to 0.
- Accept rule: i_send=1 sampled while o_busy=0 starts a message. i_send while o_busy=1 is ignored; it is neither queued nor does it restart the message. i_send held high re-triggers in the cycle after o_done.
- On accept, latch i_digit into a snapshot register. Later changes to i_digit have no effect on the message in progress.
- Saturation: a snapshot ≥ 10000 is sent as 9999.
- Digit conversion: thousands, hundreds, tens, ones, each 0x30+d. Leading zeros are sent, so the message is always 6 bytes.
- Byte order: D3 D2 D1 D0, 0x0D, 0x0A.
- Timing: o_busy rises and o_tx falls (start bit) in the cycle after i_send is sampled.
- Baud divider restarts at 0 on accept, so every bit lasts exactly DIV clocks. There is no gap between characters.
- Serializer FSM states and durations:
  - IDLE: o_tx=1.
  - START: o_tx=0, 1 bit period.
  - DATA: bits 0..7 LSB first, 1 bit period each.
  - STOP: o_tx=1, 1 bit period.
  - After STOP, return to IDLE if the last byte was sent; otherwise go to START with the next byte.
- Sequencer: a 3-bit char index 0..5, advanced at the end of each STOP.
- Message length: 60 × DIV clocks from the first start-bit cycle to the end of the final stop bit.
- Completion: o_done pulses for 1 cycle in the first cycle after the final stop bit ends. o_busy falls in that same cycle.
- o_tx is driven from a register (glitch-free). No combinational path from i_send to o_tx.
- Reset asserted mid-frame aborts immediately, with the reset values above. No partial character completes and o_done does not pulse.

Test Plan:
- CLK_HZ=1000, BAUD=100 (DIV=10). i_digit=1234, 1-cycle i_send → bytes 0x31,0x32,0x33,0x34,0x0D,0x0A decoded by the bench UART monitor. Each bit exactly 10 clocks. o_busy high 600 cycles. One o_done pulse.
- i_digit=7 → "0007\r\n" (0x30,0x30,0x30,0x37,0x0D,0x0A). i_digit=0 → 0x30×4, CR, LF.
- i_digit=12000 → "9999\r\n". i_digit=16383 → "9999\r\n". i_digit=9999 → "9999\r\n".
- Start with 1234, change i_digit to 5678 at cycle 100, pulse i_send at cycles 100 and 300 → only "1234\r\n" is sent. Exactly one o_done pulse.
- i_send held high continuously → back-to-back messages. The next start bit begins 1 cycle after each o_done. No lost or extra bytes.
- Drop reset at cycle 250 of a message → o_tx=1 and o_busy=0 immediately, no o_done. A new i_send after release yields a complete correct message.
